// File: rtl/attn_pkg.sv
// Shared constants for the attention softmax datapath: FSM encoding,
// fixed-point widths and the probability saturation helper.
package attn_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_COLLECT = 2'd0;
  localparam state_t ST_DIVIDE  = 2'd1;
  localparam state_t ST_EMIT    = 2'd2;

  localparam int N_SCORES_DEF = 4;
  localparam int EX_W  = 9;   // UQ3.6 exp score
  localparam int P_W   = 8;   // UQ0.8 probability
  localparam int DVD_W = 17;  // score scaled by 256
  localparam int Q_W   = 9;   // quotient, can reach 256

  // q == 256 only when one element holds the whole row sum
  function automatic logic [P_W-1:0] sat_prob(input logic [Q_W-1:0] q);
    return q[Q_W-1] ? {P_W{1'b1}} : q[P_W-1:0];
  endfunction

endpackage

// File: rtl/seq_div_restoring.sv
// Restoring divider producing one quotient bit per cycle; quotient is
// limited to 9 bits, which holds whenever the element does not exceed the divisor.
module seq_div_restoring
  import attn_pkg::*;
#(
  parameter int DIVISOR_W = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DVD_W-1:0]     dividend,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [Q_W-1:0]       quotient
);

  logic [DIVISOR_W-1:0] rem_r;
  logic [Q_W-1:0]       dvd_r;
  logic [DIVISOR_W-1:0] dvs_r;
  logic [Q_W-1:0]       quo_r;
  logic [3:0]           cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic [DIVISOR_W:0]   trial_s;
  logic [DIVISOR_W:0]   diff_s;
  logic                 ge_s;

  // Trial subtraction; a clear borrow bit means the divisor fits
  always_comb begin
    trial_s = {rem_r, dvd_r[Q_W-1]};
    diff_s  = trial_s - {1'b0, dvs_r};
    ge_s    = ~diff_s[DIVISOR_W];
  end

  // Iteration state: the upper dividend bits preload the remainder
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r  <= '0;
      dvd_r  <= '0;
      dvs_r  <= '0;
      quo_r  <= '0;
      cnt_r  <= 4'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      rem_r  <= DIVISOR_W'(dividend[DVD_W-1:Q_W]);
      dvd_r  <= dividend[Q_W-1:0];
      dvs_r  <= divisor;
      quo_r  <= '0;
      cnt_r  <= 4'd9;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      rem_r  <= ge_s ? diff_s[DIVISOR_W-1:0] : trial_s[DIVISOR_W-1:0];
      dvd_r  <= {dvd_r[Q_W-2:0], 1'b0};
      quo_r  <= {quo_r[Q_W-2:0], ge_s};
      cnt_r  <= cnt_r - 4'd1;
      busy_r <= (cnt_r != 4'd1);
      done_r <= (cnt_r == 4'd1);
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign quotient = quo_r;

endmodule

// File: rtl/softmax_norm.sv
// Softmax normalisation: buffers one row of exp scores, sums them and emits
// each score divided by the row sum as a UQ0.8 probability.
module softmax_norm
  import attn_pkg::*;
#(
  parameter int N_SCORES = N_SCORES_DEF,
  parameter int SUM_W    = 9 + $clog2(N_SCORES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [EX_W-1:0] ex_in,
  input  logic            ex_vld_in,
  output logic            ex_rdy_out,
  output logic [P_W-1:0]  p_out,
  output logic            p_vld_out,
  input  logic            p_rdy_in,
  output logic            p_last_out
);

  localparam int IDX_W = (N_SCORES > 1) ? $clog2(N_SCORES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SCORES - 1);
  localparam int UNIF_I = ((256 / N_SCORES) > 255) ? 255 : (256 / N_SCORES);
  localparam logic [P_W-1:0] UNIF_P = P_W'(UNIF_I);

  state_t            state_r;
  state_t            state_nx_s;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  out_idx_r;
  logic [IDX_W-1:0]  out_idx_nx_s;
  logic [IDX_W-1:0]  out_idx_inc_s;
  logic [SUM_W-1:0]  sum_r;
  logic [SUM_W-1:0]  sum_nx_s;
  logic              uniform_r;
  logic              uniform_nx_s;
  logic [EX_W-1:0]   buf_r [N_SCORES];
  logic              ex_rdy_r;
  logic              p_vld_r;
  logic              p_last_r;
  logic [P_W-1:0]    p_out_r;
  logic              in_hs_s;
  logic              out_hs_s;
  logic              last_in_s;
  logic              div_start_s;
  logic [EX_W-1:0]   div_elem_s;
  logic [SUM_W-1:0]  div_divisor_s;
  logic              div_busy_s;
  logic              div_done_s;
  logic [Q_W-1:0]    div_q_s;

  // Handshakes and the running sum; the first score of a row reloads the sum
  always_comb begin
    in_hs_s       = ex_vld_in && ex_rdy_r && (state_r == ST_COLLECT);
    out_hs_s      = p_vld_r && p_rdy_in;
    last_in_s     = (idx_r == LAST_IDX);
    out_idx_inc_s = out_idx_r + IDX_W'(1);
    if (idx_r == '0) begin
      sum_nx_s = SUM_W'(ex_in);
    end else begin
      sum_nx_s = sum_r + SUM_W'(ex_in);
    end
  end

  // Next-state logic; the divider is launched on the edge that enters DIVIDE
  always_comb begin
    state_nx_s    = state_r;
    out_idx_nx_s  = out_idx_r;
    uniform_nx_s  = uniform_r;
    div_start_s   = 1'b0;
    div_elem_s    = buf_r[out_idx_r];
    div_divisor_s = sum_r;
    case (state_r)
      ST_COLLECT: begin
        if (in_hs_s && last_in_s) begin
          out_idx_nx_s = '0;
          if (sum_nx_s == '0) begin
            state_nx_s   = ST_EMIT;
            uniform_nx_s = 1'b1;
          end else begin
            state_nx_s    = ST_DIVIDE;
            div_start_s   = 1'b1;
            div_elem_s    = (idx_r == '0) ? ex_in : buf_r[0];
            div_divisor_s = sum_nx_s;
          end
        end else begin
          state_nx_s = ST_COLLECT;
        end
      end
      ST_DIVIDE: begin
        if (div_done_s && !div_busy_s) begin
          state_nx_s = ST_EMIT;
        end else begin
          state_nx_s = ST_DIVIDE;
        end
      end
      ST_EMIT: begin
        if (out_hs_s && (out_idx_r == LAST_IDX)) begin
          state_nx_s   = ST_COLLECT;
          out_idx_nx_s = '0;
          uniform_nx_s = 1'b0;
        end else if (out_hs_s) begin
          out_idx_nx_s = out_idx_inc_s;
          if (uniform_r) begin
            state_nx_s = ST_EMIT;
          end else begin
            state_nx_s    = ST_DIVIDE;
            div_start_s   = 1'b1;
            div_elem_s    = buf_r[out_idx_inc_s];
            div_divisor_s = sum_r;
          end
        end else begin
          state_nx_s = ST_EMIT;
        end
      end
      default: begin
        state_nx_s   = ST_COLLECT;
        out_idx_nx_s = '0;
        uniform_nx_s = 1'b0;
      end
    endcase
  end

  // FSM, row buffer and registered outputs derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_COLLECT;
      idx_r     <= '0;
      out_idx_r <= '0;
      sum_r     <= '0;
      uniform_r <= 1'b0;
      for (int i = 0; i < N_SCORES; i++) begin
        buf_r[i] <= '0;
      end
      ex_rdy_r  <= 1'b1;
      p_vld_r   <= 1'b0;
      p_last_r  <= 1'b0;
      p_out_r   <= '0;
    end else begin
      state_r   <= state_nx_s;
      out_idx_r <= out_idx_nx_s;
      uniform_r <= uniform_nx_s;
      if (in_hs_s) begin
        buf_r[idx_r] <= ex_in;
        sum_r        <= sum_nx_s;
        idx_r        <= last_in_s ? '0 : idx_r + IDX_W'(1);
      end
      ex_rdy_r <= (state_nx_s == ST_COLLECT);
      p_vld_r  <= (state_nx_s == ST_EMIT);
      p_last_r <= (state_nx_s == ST_EMIT) && (out_idx_nx_s == LAST_IDX);
      if (state_nx_s == ST_EMIT) begin
        p_out_r <= uniform_nx_s ? UNIF_P : sat_prob(div_q_s);
      end
    end
  end

  seq_div_restoring #(
    .DIVISOR_W(SUM_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_s),
    .dividend ({div_elem_s, 8'd0}),
    .divisor  (div_divisor_s),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (div_q_s)
  );

  assign ex_rdy_out = ex_rdy_r;
  assign p_vld_out  = p_vld_r;
  assign p_last_out = p_last_r;
  assign p_out      = p_out_r;

endmodule

// File: tb/tb_softmax_norm.sv
// Directed bench for softmax_norm: hand-computed rows, latency, stall and
// mid-row reset behaviour.
module tb_softmax_norm;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] ex_in;
  logic       ex_vld_in;
  logic       ex_rdy_out;
  logic [7:0] p_out;
  logic       p_vld_out;
  logic       p_rdy_in;
  logic       p_last_out;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int t_last     = 0;
  int t_vld [4];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  softmax_norm dut (
    .clk        (clk),
    .rst        (rst),
    .ex_in      (ex_in),
    .ex_vld_in  (ex_vld_in),
    .ex_rdy_out (ex_rdy_out),
    .p_out      (p_out),
    .p_vld_out  (p_vld_out),
    .p_rdy_in   (p_rdy_in),
    .p_last_out (p_last_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_row(input logic [8:0] a, input logic [8:0] b,
                          input logic [8:0] c, input logic [8:0] d);
    logic [8:0] v [4];
    int n;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ex_in     = v[i];
      ex_vld_in = 1'b1;
      n = 0;
      while (ex_rdy_out !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("ex_rdy_wait", 32'(n < 100), 32'd1);
      @(posedge clk);
      #1;
      ex_vld_in = 1'b0;
    end
    t_last = cyc;
  endtask

  task automatic collect_row(input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input int stall, input logic uniform);
    logic [7:0] e [4];
    int n;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (p_vld_out !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("p_vld_wait", 32'(n < 100), 32'd1);
      t_vld[i] = cyc;
      check("p_out", 32'(p_out), 32'(e[i]));
      check("p_last", 32'(p_last_out), 32'(i == 3));
      if (stall > 0) begin
        ex_vld_in = 1'b1;
        ex_in     = 9'h1FF;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check("stall_vld", 32'(p_vld_out), 32'd1);
          check("stall_pout", 32'(p_out), 32'(e[i]));
          check("stall_last", 32'(p_last_out), 32'(i == 3));
          check("stall_ex_rdy", 32'(ex_rdy_out), 32'd0);
        end
        ex_vld_in = 1'b0;
        p_rdy_in  = 1'b1;
      end
      @(posedge clk);
      #1;
      if (stall > 0) p_rdy_in = 1'b0;
      @(negedge clk);
      if (i == 3) begin
        check("ex_rdy_after_row", 32'(ex_rdy_out), 32'd1);
        check("p_vld_after_row", 32'(p_vld_out), 32'd0);
      end else if (!uniform) begin
        check("p_vld_drop", 32'(p_vld_out), 32'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    ex_vld_in = 1'b0;
    ex_in     = 9'd0;
    p_rdy_in  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ex_rdy", 32'(ex_rdy_out), 32'd1);
    check("rst_p_vld", 32'(p_vld_out), 32'd0);
    check("rst_p_out", 32'(p_out), 32'd0);
    check("rst_p_last", 32'(p_last_out), 32'd0);
    rst = 1'b0;

    // uniform inputs, latency and per-element spacing
    send_row(9'd64, 9'd64, 9'd64, 9'd64);
    collect_row(8'd64, 8'd64, 8'd64, 8'd64, 0, 1'b0);
    check("latency_first", 32'(t_vld[0] - t_last), 32'd10);
    for (int i = 1; i < 4; i++) check("spacing", 32'(t_vld[i] - t_vld[i-1]), 32'd11);

    send_row(9'd256, 9'd0, 9'd0, 9'd0);
    collect_row(8'd255, 8'd0, 8'd0, 8'd0, 0, 1'b0);

    send_row(9'd192, 9'd64, 9'd0, 9'd0);
    collect_row(8'd192, 8'd64, 8'd0, 8'd0, 0, 1'b0);

    // zero sum goes straight to EMIT
    send_row(9'd0, 9'd0, 9'd0, 9'd0);
    collect_row(8'd64, 8'd64, 8'd64, 8'd64, 0, 1'b1);
    check("latency_uniform", 32'(t_vld[0] - t_last), 32'd0);

    send_row(9'd511, 9'd511, 9'd511, 9'd511);
    collect_row(8'd64, 8'd64, 8'd64, 8'd64, 0, 1'b0);
    check("latency_max", 32'(t_vld[0] - t_last), 32'd10);

    // downstream stall with ignored upstream traffic
    p_rdy_in = 1'b0;
    send_row(9'd100, 9'd50, 9'd25, 9'd25);
    collect_row(8'd128, 8'd64, 8'd32, 8'd32, 20, 1'b0);
    p_rdy_in = 1'b1;

    // reset while element 1 is dividing
    send_row(9'd64, 9'd64, 9'd64, 9'd64);
    n = 0;
    @(negedge clk);
    while (p_vld_out !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_vld_wait", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1;
    repeat (3) @(negedge clk);
    check("divide_ex_rdy", 32'(ex_rdy_out), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_p_vld", 32'(p_vld_out), 32'd0);
    check("mid_rst_ex_rdy", 32'(ex_rdy_out), 32'd1);
    check("mid_rst_p_last", 32'(p_last_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_row(9'd64, 9'd64, 9'd64, 9'd64);
    collect_row(8'd64, 8'd64, 8'd64, 8'd64, 0, 1'b0);
    check("latency_post_rst", 32'(t_vld[0] - t_last), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/softmax_norm.md
SOFTMAX_NORM -- requirements
Module: softmax_norm

Interface
REQ-001 SHALL have parameter N_SCORES, default 4: number of exp scores per softmax row.
REQ-002 SHALL have parameter SUM_W, default 11: width of the row-sum accumulator, equal to 9+clog2(N_SCORES).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port ex_in, input, 9: unsigned UQ3.6 exp score from the upstream exp stage.
REQ-006 SHALL have port ex_vld_in, input, 1: ex_in valid.
REQ-007 SHALL have port ex_rdy_out, output, 1: block accepts ex_in.
REQ-008 SHALL have port p_out, output, 8: normalized probability, UQ0.8.
REQ-009 SHALL have port p_vld_out, output, 1: p_out valid.
REQ-010 SHALL have port p_rdy_in, input, 1: downstream accepts p_out.
REQ-011 SHALL have port p_last_out, output, 1: high with the final probability of a row.

Function
REQ-012 SHALL implement FSM states COLLECT, DIVIDE and EMIT.
REQ-013 SHALL accept an input only on a handshake (ex_vld_in & ex_rdy_out); ex_rdy_out is high only in COLLECT.
REQ-014 In COLLECT, each handshake SHALL store ex_in into buffer[idx], add it to sum, and increment idx.
REQ-015 The first handshake of a row SHALL load sum with ex_in rather than accumulate it.
REQ-016 On the N_SCORES-th handshake, the FSM SHALL go to DIVIDE with out_idx=0, or to EMIT with uniform mode set if the final sum is 0.
REQ-017 DIVIDE SHALL be a restoring divider computing q = floor(buffer[out_idx]*256 / sum).
  - 17-bit numerator, 9 quotient bits.
  - Exactly one quotient bit per cycle, so 9 cycles in DIVIDE per element.
  - The FSM then goes to EMIT.
REQ-018 p_out SHALL be min(q,255), since q=256 occurs only when the element equals the sum.
REQ-019 In uniform mode, p_out SHALL be 256/N_SCORES (64 for the default) for every element.
REQ-020 In EMIT, p_vld_out SHALL be 1 and p_out and p_last_out SHALL be held stable until p_rdy_in.
  - p_last_out = (out_idx == N_SCORES-1).
REQ-021 On an EMIT handshake with out_idx < N_SCORES-1, the FSM SHALL increment out_idx and go to DIVIDE, or stay in EMIT for the next element in uniform mode.
REQ-022 On an EMIT handshake with the last element, the FSM SHALL go to COLLECT with idx=0 and uniform cleared; ex_rdy_out is high the following cycle.
REQ-023 p_vld_out SHALL drop in the cycle after the handshake.
  - No combinational path from p_rdy_in to p_vld_out.
  - No combinational path from ex_vld_in to ex_rdy_out.
REQ-024 Latency, for a non-zero sum:
  - First p_vld_out rises 10 cycles after the final input handshake edge (9 DIVIDE cycles + EMIT entry).
  - With p_rdy_in held high, each subsequent element follows every 11 cycles.
REQ-025 ex_vld_in while not in COLLECT SHALL be ignored and have no effect on state.
REQ-026 sum SHALL never overflow: max 511*N_SCORES fits SUM_W bits.

Reset
REQ-027 On rst, the state SHALL be COLLECT, idx=0, out_idx=0, sum=0, uniform=0, divider registers=0 and buffer=0.
REQ-028 Output reset values SHALL be ex_rdy_out=1 (the reset state is COLLECT), p_vld_out=0, p_out=0 and p_last_out=0.
REQ-029 Reset asserted mid-row, in any state, SHALL discard the partial row; the first post-reset input SHALL be treated as element 0.

Structure
REQ-030 State encoding typedef, N_SCORES default and the UQ3.6/UQ0.8 width constants SHALL reside in a shared package, attn_pkg.
REQ-031 The divider SHALL be a separate sub-module, seq_div_restoring (start/busy/done, 17-bit dividend, SUM_W-bit divisor, 9-bit quotient), instantiated once.

Verification
REQ-032 Inputs 64,64,64,64 with p_rdy_in=1 -> p_out 64,64,64,64; p_last_out only on the 4th; first p_vld_out 10 cycles after the 4th input edge.
REQ-033 Inputs 256,0,0,0 -> p_out 255,0,0,0 (saturation); inputs 192,64,0,0 -> 192,64,0,0.
REQ-034 Inputs 0,0,0,0 -> p_out 64,64,64,64 with no DIVIDE cycles; inputs 511,511,511,511 (sum 2044) -> 64 each.
REQ-035 Inputs 100,50,25,25 with p_rdy_in low for 20 cycles during each EMIT -> p_out 128,64,32,32, stable while stalled; ex_rdy_out low until the last handshake.
REQ-036 rst pulsed during DIVIDE of element 1 -> p_vld_out=0 and ex_rdy_out=1 immediately; next row 64,64,64,64 -> 64 each.
